// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default datapath widths and the MEM->WB payload record.
package pipe_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_RD_W = 5;

    typedef struct packed {
        logic                regwrite;
        logic                memtoreg;
        logic [DEF_XLEN-1:0] alu;
        logic [DEF_XLEN-1:0] mem;
        logic [DEF_RD_W-1:0] rd;
    } wb_payload_t;

    // Writeback value of a payload: memory data for loads, ALU result otherwise.
    function automatic logic [DEF_XLEN-1:0] wb_select(input wb_payload_t p);
        return p.memtoreg ? p.mem : p.alu;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry (head H + skid S) valid/ready buffer with flush; ready_o is registered
// as !S.v so the upstream path never sees a combinational dependency on ready_i.
module pipe_skid_buf #(
    parameter type T = logic [7:0]
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_i,
    input  logic valid_i,
    input  T     data_i,
    output logic ready_o,
    output logic valid_o,
    input  logic ready_i,
    output T     data_o,
    output logic skid_valid_o,
    output T     skid_data_o
);

    logic h_v_q, h_v_d, s_v_q, s_v_d, ready_q;
    T     h_q, h_d, s_q, s_d;
    logic accept, pop;

    assign accept = valid_i & ready_q;
    assign pop    = h_v_q & ready_i;

    // NOTE: every next-state value gets a hold default first, so no branch can infer a latch.
    always_comb begin
        h_v_d = h_v_q;
        s_v_d = s_v_q;
        h_d   = h_q;
        s_d   = s_q;
        if (flush_i) begin
            h_v_d = 1'b0;
            s_v_d = 1'b0;
        end else if (pop) begin
            if (s_v_q) begin
                h_d = s_q;
                if (accept) s_d = data_i;
                else        s_v_d = 1'b0;
            end else if (accept) begin
                h_d = data_i;
            end else begin
                h_v_d = 1'b0;
            end
        end else if (!h_v_q) begin
            if (accept) begin
                h_d   = data_i;
                h_v_d = 1'b1;
            end
        end else if (accept) begin
            s_d   = data_i;
            s_v_d = 1'b1;
        end
    end

    // NOTE: payload is cleared on reset too, so reset state is fully deterministic.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            h_v_q   <= 1'b0;
            s_v_q   <= 1'b0;
            h_q     <= '0;
            s_q     <= '0;
            ready_q <= 1'b0;
        end else begin
            h_v_q   <= h_v_d;
            s_v_q   <= s_v_d;
            h_q     <= h_d;
            s_q     <= s_d;
            ready_q <= !s_v_d;
        end
    end

    assign ready_o      = ready_q;
    assign valid_o      = h_v_q;
    assign data_o       = h_q;
    assign skid_valid_o = s_v_q;
    assign skid_data_o  = s_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline stage: skid-buffered handshake, x0 write masking and writeback mux.
// Optional EX forwarding outputs are enabled by defining MEM_WB_STAGE_FWD_EN.
module mem_wb_stage
    import pipe_pkg::*;
#(
    parameter int XLEN      = DEF_XLEN,
    parameter int RD_W      = DEF_RD_W,
    parameter int ZERO_MASK = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic            regwrite_i,
    input  logic            memtoreg_i,
    input  logic [XLEN-1:0] aluresult_i,
    input  logic [XLEN-1:0] rddata_i,
    input  logic [RD_W-1:0] rd_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic            regwrite_o,
    output logic [RD_W-1:0] rd_o,
`ifdef MEM_WB_STAGE_FWD_EN
    output logic            fwd_valid_o,
    output logic [RD_W-1:0] fwd_rd_o,
    output logic [XLEN-1:0] fwd_data_o,
`endif
    output logic [XLEN-1:0] wbdata_o
);

    // The payload record is sized by the package; XLEN/RD_W must match its defaults.
    wb_payload_t in_p, head, skid;
    logic        skid_v;
    logic        rd_nonzero;

    assign rd_nonzero = (rd_i != '0);

    always_comb begin
        in_p          = '0;
        in_p.regwrite = regwrite_i & ((ZERO_MASK == 0) | rd_nonzero);
        in_p.memtoreg = memtoreg_i;
        in_p.alu      = aluresult_i;
        in_p.mem      = rddata_i;
        in_p.rd       = rd_i;
    end

    pipe_skid_buf #(.T(wb_payload_t)) u_buf (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .valid_i      (valid_i),
        .data_i       (in_p),
        .ready_o      (ready_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .data_o       (head),
        .skid_valid_o (skid_v),
        .skid_data_o  (skid)
    );

    assign regwrite_o = valid_o & head.regwrite;
    assign rd_o       = head.rd;
    assign wbdata_o   = wb_select(head);

`ifdef MEM_WB_STAGE_FWD_EN
    logic s_ok, h_ok;

    // Skid holds the younger instruction, so it wins when both write a register.
    assign s_ok        = skid_v & skid.regwrite & (skid.rd != '0);
    assign h_ok        = valid_o & head.regwrite & (head.rd != '0);
    assign fwd_valid_o = rst_i & (s_ok | h_ok);
    assign fwd_rd_o    = s_ok ? skid.rd : head.rd;
    assign fwd_data_o  = s_ok ? wb_select(skid) : wb_select(head);
`else
    logic unused_skid;
    assign unused_skid = ^{skid_v, skid};
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage; forwarding checks run when
// MEM_WB_STAGE_FWD_EN is defined.
module tb_mem_wb_stage;

    logic        clk_i = 1'b0;
    logic        rst_i, flush_i, valid_i, ready_o;
    logic        regwrite_i, memtoreg_i;
    logic [31:0] aluresult_i, rddata_i;
    logic [4:0]  rd_i;
    logic        valid_o, ready_i, regwrite_o;
    logic [4:0]  rd_o;
    logic [31:0] wbdata_o;
`ifdef MEM_WB_STAGE_FWD_EN
    logic        fwd_valid_o;
    logic [4:0]  fwd_rd_o;
    logic [31:0] fwd_data_o;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    mem_wb_stage dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .regwrite_i  (regwrite_i),
        .memtoreg_i  (memtoreg_i),
        .aluresult_i (aluresult_i),
        .rddata_i    (rddata_i),
        .rd_i        (rd_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .regwrite_o  (regwrite_o),
        .rd_o        (rd_o),
`ifdef MEM_WB_STAGE_FWD_EN
        .fwd_valid_o (fwd_valid_o),
        .fwd_rd_o    (fwd_rd_o),
        .fwd_data_o  (fwd_data_o),
`endif
        .wbdata_o    (wbdata_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle before sampling.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic offer(input logic v, input logic rw, input logic m2r,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [4:0] rd);
        valid_i     = v;
        regwrite_i  = rw;
        memtoreg_i  = m2r;
        aluresult_i = alu;
        rddata_i    = mem;
        rd_i        = rd;
    endtask

    initial begin
        rst_i   = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b0;
        offer(1'b1, 1'b1, 1'b0, 32'h55, 32'h0, 5'd1);

        // Reset held two cycles with a pending offer.
        step();
        step();
        check("rst_valid",    {31'b0, valid_o},    32'd0);
        check("rst_regwrite", {31'b0, regwrite_o}, 32'd0);
        check("rst_ready",    {31'b0, ready_o},    32'd0);

        rst_i = 1'b1;
        offer(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        step();
        check("post_rst_ready", {31'b0, ready_o}, 32'd1);
        check("post_rst_valid", {31'b0, valid_o}, 32'd0);

        // Streaming with continuous ready_i.
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, 1'b1, 1'b0, 32'h10 + i, 32'hFFFF_0000, 5'd7);
            step();
            check("stream_valid", {31'b0, valid_o}, 32'd1);
            check("stream_data",  wbdata_o,         32'h10 + i);
            check("stream_ready", {31'b0, ready_o}, 32'd1);
        end
        offer(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        step();
        check("stream_drain", {31'b0, valid_o}, 32'd0);

        // Back-pressure: A, B fill H and S; a third offer must be refused.
        ready_i = 1'b0;
        offer(1'b1, 1'b1, 1'b0, 32'hA, 32'h0, 5'd3);
        step();
        check("bp_a_rd",    {27'b0, rd_o},       32'd3);
        check("bp_a_ready", {31'b0, ready_o},    32'd1);
        offer(1'b1, 1'b1, 1'b0, 32'hB, 32'h0, 5'd4);
        step();
        check("bp_b_ready", {31'b0, ready_o},    32'd0);
        offer(1'b1, 1'b1, 1'b0, 32'hC6, 32'h0, 5'd6);
        step();
        check("bp_third_rd",    {27'b0, rd_o},    32'd3);
        check("bp_third_ready", {31'b0, ready_o}, 32'd0);
        offer(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        ready_i = 1'b1;
        check("bp_a_data", wbdata_o, 32'hA);
        step();
        check("bp_b_rd",    {27'b0, rd_o},    32'd4);
        check("bp_b_data",  wbdata_o,         32'hB);
        check("bp_b_ready", {31'b0, ready_o}, 32'd1);
        step();
        check("bp_empty", {31'b0, valid_o}, 32'd0);

        // Flush with both entries held and a concurrent offer C.
        ready_i = 1'b0;
        offer(1'b1, 1'b1, 1'b0, 32'hD1, 32'h0, 5'd8);
        step();
        offer(1'b1, 1'b1, 1'b0, 32'hE1, 32'h0, 5'd9);
        step();
        check("fl_full_ready", {31'b0, ready_o}, 32'd0);
        flush_i = 1'b1;
        offer(1'b1, 1'b1, 1'b0, 32'hCC, 32'h0, 5'd10);
        step();
        check("fl_valid",    {31'b0, valid_o},    32'd0);
        check("fl_ready",    {31'b0, ready_o},    32'd1);
        check("fl_regwrite", {31'b0, regwrite_o}, 32'd0);
        flush_i = 1'b0;
        offer(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        step();
        check("fl_c_absent", {31'b0, valid_o}, 32'd0);

        // Writeback mux and x0 masking.
        offer(1'b1, 1'b1, 1'b1, 32'h1, 32'hDEAD_BEEF, 5'd12);
        step();
        check("mux_mem",      wbdata_o,            32'hDEAD_BEEF);
        check("mux_regwrite", {31'b0, regwrite_o}, 32'd1);
        ready_i = 1'b1;
        offer(1'b1, 1'b1, 1'b0, 32'h77, 32'h0, 5'd0);
        step();
        check("x0_valid",    {31'b0, valid_o},    32'd1);
        check("x0_rd",       {27'b0, rd_o},       32'd0);
        check("x0_regwrite", {31'b0, regwrite_o}, 32'd0);
        check("x0_alu",      wbdata_o,            32'h77);
        offer(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        step();
        check("x0_drain", {31'b0, valid_o}, 32'd0);

`ifdef MEM_WB_STAGE_FWD_EN
        // Forwarding: youngest held writer of rd=5 wins.
        check("fwd_idle", {31'b0, fwd_valid_o}, 32'd0);
        ready_i = 1'b0;
        offer(1'b1, 1'b1, 1'b0, 32'h11, 32'h0, 5'd5);
        step();
        check("fwd_h_valid", {31'b0, fwd_valid_o}, 32'd1);
        check("fwd_h_rd",    {27'b0, fwd_rd_o},    32'd5);
        check("fwd_h_data",  fwd_data_o,           32'h11);
        offer(1'b1, 1'b1, 1'b0, 32'h22, 32'h0, 5'd5);
        step();
        check("fwd_s_data",  fwd_data_o,           32'h22);
        check("fwd_s_valid", {31'b0, fwd_valid_o}, 32'd1);
        flush_i = 1'b1;
        offer(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        step();
        flush_i = 1'b0;
        check("fwd_flushed", {31'b0, fwd_valid_o}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
